// File: rtl/iserdes_align_ctrl.sv
// Word-alignment training controller for one I_SERDES lane (bitslip + delay-tap search).
// Define ISERDES_ALIGN_MONITOR_EN to enable loss-of-lock detection and automatic retraining.
module iserdes_align_ctrl #(
    parameter int unsigned        WIDTH         = 4,
    parameter logic [WIDTH-1:0]   TRAIN_PATTERN = 4'b1100,
    parameter int unsigned        MATCH_COUNT   = 16,
    parameter int unsigned        SLIP_WAIT     = 4,
    parameter int unsigned        MAX_TAPS      = 63,
    parameter int unsigned        LOSS_LIMIT    = 4,
    localparam int unsigned       SlipW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             pll_lock_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             data_valid_i,
    output logic             fifo_rst_o,
    output logic             bitslip_adj_o,
    output logic             dly_load_o,
    output logic             dly_adj_o,
    output logic             dly_incdec_o,
    output logic             busy_o,
    output logic             aligned_o,
    output logic             align_error_o,
    output logic [SlipW-1:0] slip_cnt_o,
    output logic [5:0]       tap_cnt_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FRST   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] SLIP   = 3'd4;
    localparam logic [2:0] STEP   = 3'd5;
    localparam logic [2:0] LOCKED = 3'd6;
    localparam logic [2:0] FAIL   = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [7:0]       match_q, match_d;
    logic [SlipW-1:0] slip_q, slip_d;
    logic [5:0]       tap_q, tap_d;
    logic             err_q, err_d;
`ifdef ISERDES_ALIGN_MONITOR_EN
    logic [3:0]       loss_q, loss_d;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        match_d = match_q;
        slip_d  = slip_q;
        tap_d   = tap_q;
        err_d   = err_q;
`ifdef ISERDES_ALIGN_MONITOR_EN
        loss_d  = loss_q;
`endif
        case (state_q)
            IDLE: begin
                slip_d = '0;
                tap_d  = '0;
                if (start_i && pll_lock_i) begin
                    state_d = FRST;
                    wait_d  = '0;
                    err_d   = 1'b0;
                end
            end
            FRST: begin
                // FIFO reset spans two cycles; the delay reload only the first.
                if (wait_q == 4'd1) begin
                    state_d = SETTLE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            SETTLE: begin
                if (wait_q >= 4'(SLIP_WAIT - 1)) begin
                    state_d = CHECK;
                    wait_d  = '0;
                    match_d = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            CHECK: begin
                if (data_valid_i) begin
                    if (q_i == TRAIN_PATTERN) begin
                        match_d = (match_q == 8'hFF) ? match_q : match_q + 8'd1;
                        if (match_d >= 8'(MATCH_COUNT)) begin
                            state_d = LOCKED;
`ifdef ISERDES_ALIGN_MONITOR_EN
                            loss_d  = '0;
`endif
                        end
                    end else begin
                        match_d = '0;
                        if (slip_q < SlipW'(WIDTH - 1)) begin
                            state_d = SLIP;
                        end else if (tap_q < 6'(MAX_TAPS)) begin
                            state_d = STEP;
                        end else begin
                            state_d = FAIL;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            SLIP: begin
                slip_d  = (slip_q == SlipW'(WIDTH - 1)) ? slip_q : slip_q + 1'b1;
                state_d = SETTLE;
                wait_d  = '0;
            end
            STEP: begin
                tap_d   = (tap_q == 6'h3F) ? tap_q : tap_q + 6'd1;
                slip_d  = '0;
                state_d = SETTLE;
                wait_d  = '0;
            end
            LOCKED: begin
`ifdef ISERDES_ALIGN_MONITOR_EN
                if (data_valid_i) begin
                    if (q_i == TRAIN_PATTERN) begin
                        loss_d = '0;
                    end else if (loss_q >= 4'(LOSS_LIMIT - 1)) begin
                        state_d = FRST;
                        wait_d  = '0;
                        slip_d  = '0;
                        tap_d   = '0;
                        loss_d  = '0;
                    end else begin
                        loss_d = loss_q + 4'd1;
                    end
                end
`endif
            end
            FAIL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Losing the PLL overrides everything; sticky error and counters are kept.
        if (!pll_lock_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            match_q <= '0;
            slip_q  <= '0;
            tap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            match_q <= match_d;
            slip_q  <= slip_d;
            tap_q   <= tap_d;
            err_q   <= err_d;
        end
    end

`ifdef ISERDES_ALIGN_MONITOR_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end
`endif

    assign fifo_rst_o    = (state_q == FRST);
    assign dly_load_o    = (state_q == FRST) && (wait_q == 4'd0);
    assign bitslip_adj_o = (state_q == SLIP);
    assign dly_adj_o     = (state_q == STEP);
    assign dly_incdec_o  = 1'b1;
    assign busy_o        = (state_q == FRST) || (state_q == SETTLE) || (state_q == CHECK) ||
                           (state_q == SLIP) || (state_q == STEP);
    assign aligned_o     = (state_q == LOCKED);
    assign align_error_o = err_q;
    assign slip_cnt_o    = slip_q;
    assign tap_cnt_o     = tap_q;

endmodule

// File: tb/tb_iserdes_align_ctrl.sv
// Directed bench for iserdes_align_ctrl: a rotating-word lane model driven by the DUT's
// bitslip/delay pulses, a vector table for lock scenarios, and hand sequences for corner cases.
module tb_iserdes_align_ctrl;

    localparam logic [3:0] PAT = 4'b1100;

    logic       clk = 1'b0;
    logic       rst_n, start, pll_lock, data_valid;
    logic [3:0] q;

    logic       fifo_rst, bitslip, dly_load, dly_adj, incdec, busy, aligned, aerr;
    logic [1:0] slip_cnt;
    logic [5:0] tap_cnt;

    logic       f_fifo_rst, f_bitslip, f_dly_load, f_dly_adj, f_incdec, f_busy, f_aligned, f_aerr;
    logic [1:0] f_slip_cnt;
    logic [5:0] f_tap_cnt;

    iserdes_align_ctrl #(
        .WIDTH(4), .TRAIN_PATTERN(PAT), .MATCH_COUNT(4), .SLIP_WAIT(2), .MAX_TAPS(63),
        .LOSS_LIMIT(4)
    ) u_dut (
        .clk_i(clk), .rst_n(rst_n), .start_i(start), .pll_lock_i(pll_lock), .q_i(q),
        .data_valid_i(data_valid), .fifo_rst_o(fifo_rst), .bitslip_adj_o(bitslip),
        .dly_load_o(dly_load), .dly_adj_o(dly_adj), .dly_incdec_o(incdec), .busy_o(busy),
        .aligned_o(aligned), .align_error_o(aerr), .slip_cnt_o(slip_cnt), .tap_cnt_o(tap_cnt)
    );

    iserdes_align_ctrl #(
        .WIDTH(4), .TRAIN_PATTERN(PAT), .MATCH_COUNT(4), .SLIP_WAIT(2), .MAX_TAPS(2),
        .LOSS_LIMIT(4)
    ) u_fail (
        .clk_i(clk), .rst_n(rst_n), .start_i(start), .pll_lock_i(pll_lock), .q_i(q),
        .data_valid_i(data_valid), .fifo_rst_o(f_fifo_rst), .bitslip_adj_o(f_bitslip),
        .dly_load_o(f_dly_load), .dly_adj_o(f_dly_adj), .dly_incdec_o(f_incdec),
        .busy_o(f_busy), .aligned_o(f_aligned), .align_error_o(f_aerr),
        .slip_cnt_o(f_slip_cnt), .tap_cnt_o(f_tap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r0;
        int bad;
        int e_slip;
        int e_tap;
        int e_bs;
        int e_adj;
    } vec_t;
    vec_t vecs [6];

    int n_cmp = 0;
    int n_err = 0;
    int rot, rot0, bad_taps, tap_m, cyc;
    bit const_zero, valid_gaps, valid_off, force_bad;
    int n_fifo, n_load, n_slip, n_adj, f_n_slip, f_n_adj;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Lane model: word = PAT rotated by rot; each bitslip advances alignment by one bit,
    // a delay reload or step re-phases the lane back to its starting rotation.
    task automatic drive();
        logic [7:0] dbl;
        dbl = {PAT, PAT};
        data_valid = !valid_off && !(valid_gaps && (cyc % 3 == 2));
        if (force_bad) begin
            q = 4'b0000;
            data_valid = 1'b1;
        end else if (!data_valid) begin
            q = 4'b0011;
        end else if (const_zero || tap_m < bad_taps) begin
            q = 4'b0000;
        end else begin
            q = 4'(dbl >> rot);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (fifo_rst) n_fifo++;
        if (dly_load) n_load++;
        if (bitslip) n_slip++;
        if (dly_adj) n_adj++;
        if (f_bitslip) f_n_slip++;
        if (f_dly_adj) f_n_adj++;
        if (bitslip) rot = (rot + 3) % 4;
        if (dly_load) begin
            rot = rot0;
            tap_m = 0;
        end
        if (dly_adj) begin
            rot = rot0;
            tap_m++;
        end
        drive();
    endtask

    task automatic do_reset(input int r0, input int bad, input bit gaps);
        rst_n = 1'b0;
        start = 1'b0;
        pll_lock = 1'b1;
        rot0 = r0;
        rot = r0;
        bad_taps = bad;
        tap_m = 0;
        valid_gaps = gaps;
        const_zero = 1'b0;
        valid_off = 1'b0;
        force_bad = 1'b0;
        cyc = 0;
        drive();
        tick();
        tick();
        chk("reset_outs", int'({fifo_rst, bitslip, dly_load, dly_adj, busy, aligned, aerr,
                               slip_cnt, tap_cnt}), 0);
        chk("reset_incdec", int'(incdec), 1);
        n_fifo = 0; n_load = 0; n_slip = 0; n_adj = 0; f_n_slip = 0; f_n_adj = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_lock(input string name);
        for (int i = 0; i < 3000 && !aligned; i++) tick();
        chk(name, int'(aligned), 1);
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 1, 0, 1, 0};
        vecs[2] = '{2, 0, 2, 0, 2, 0};
        vecs[3] = '{3, 0, 3, 0, 3, 0};
        vecs[4] = '{0, 3, 0, 3, 9, 3};
        vecs[5] = '{2, 1, 2, 1, 5, 1};

        // Lock scenarios with DATA_VALID gaps carrying a non-pattern word.
        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].r0, vecs[v].bad, 1'b1);
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_lock($sformatf("v%0d_lock", v));
            chk($sformatf("v%0d_slip_cnt", v), int'(slip_cnt), vecs[v].e_slip);
            chk($sformatf("v%0d_tap_cnt", v), int'(tap_cnt), vecs[v].e_tap);
            chk($sformatf("v%0d_bitslips", v), n_slip, vecs[v].e_bs);
            chk($sformatf("v%0d_dly_adjs", v), n_adj, vecs[v].e_adj);
            chk($sformatf("v%0d_fifo_rst_cycles", v), n_fifo, 2);
            chk($sformatf("v%0d_dly_loads", v), n_load, 1);
            repeat (6) tick();
            chk($sformatf("v%0d_hold", v), int'({aligned, busy, aerr}), 3'b100);
        end

        // Exact lock latency with gapless valid data.
        do_reset(0, 0, 1'b0);
        start = 1'b1;
        tick();
        chk("t1_frst_first", int'({fifo_rst, dly_load, busy}), 3'b111);
        start = 1'b0;
        tick();
        chk("t2_frst_second", int'({fifo_rst, dly_load}), 2'b10);
        tick();
        chk("t3_settle", int'({fifo_rst, busy}), 2'b01);
        repeat (5) tick();
        chk("t8_not_yet", int'(aligned), 0);
        tick();
        chk("t9_aligned", int'({aligned, busy}), 2'b10);

        // Asynchronous reset while a bitslip pulse is high.
        do_reset(3, 0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && !bitslip; i++) tick();
        chk("arst_saw_slip", int'(bitslip), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cleared", int'({bitslip, busy, fifo_rst, slip_cnt}), 0);

        // Exhaustion on the MAX_TAPS=2 instance.
        do_reset(0, 0, 1'b0);
        const_zero = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3000 && !f_aerr; i++) tick();
        chk("fail_err", int'(f_aerr), 1);
        chk("fail_busy_aligned", int'({f_busy, f_aligned}), 0);
        chk("fail_bitslips", f_n_slip, 9);
        chk("fail_dly_adjs", f_n_adj, 2);
        chk("fail_counts", int'({f_slip_cnt, f_tap_cnt}), {2'd3, 6'd2});
        repeat (3) tick();
        chk("fail_sticky", int'({f_aerr, f_fifo_rst, f_busy, f_incdec}), 4'b1001);
        start = 1'b1;
        tick();
        chk("fail_restart", int'({f_fifo_rst, f_dly_load, f_aerr}), 3'b110);

        // PLL loss while parked in CHECK (no valid data), then restart.
        do_reset(0, 0, 1'b0);
        valid_off = 1'b1;
        start = 1'b1;
        repeat (8) tick();
        chk("pll_in_check", int'({busy, aligned, fifo_rst}), 3'b100);
        pll_lock = 1'b0;
        start = 1'b0;
        tick();
        chk("pll_drop", int'({busy, fifo_rst, bitslip, dly_adj, dly_load}), 0);
        pll_lock = 1'b1;
        start = 1'b1;
        tick();
        chk("pll_restart", int'({fifo_rst, dly_load, busy}), 3'b111);

        // Post-lock bad words.
        do_reset(2, 1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_lock("mon_lock");
        n_fifo = 0;
        force_bad = 1'b1;
        repeat (4) tick();
        force_bad = 1'b0;
        tick();
`ifdef ISERDES_ALIGN_MONITOR_EN
        chk("mon_4bad_aligned", int'(aligned), 0);
        chk("mon_4bad_retrain", int'({fifo_rst, slip_cnt, tap_cnt}), {1'b1, 2'd0, 6'd0});
`else
        chk("mon_4bad_aligned", int'(aligned), 1);
        chk("mon_4bad_retrain", int'({fifo_rst, slip_cnt, tap_cnt}), {1'b0, 2'd2, 6'd1});
`endif
        wait_lock("mon_relock");
        force_bad = 1'b1;
        repeat (3) tick();
        force_bad = 1'b0;
        repeat (2) tick();
        chk("mon_3bad_1good", int'(aligned), 1);
        force_bad = 1'b1;
        repeat (3) tick();
        force_bad = 1'b0;
        repeat (2) tick();
        chk("mon_3bad_again", int'({aligned, fifo_rst}), 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
